// File: rtl/uidbuf_w_quad_baseaddr.sv
// Quad-split write-channel frame buffer: pixel stream -> async FIFO -> FDMA write bursts at a per-frame quadrant base.
// Optional build macro UIDBUF_W_OVF_FLAG_EN adds the sticky O_W_ovf overflow flag in the I_W_clk domain.

// Async width-up FIFO, show-ahead read; writes are dropped while full.
module uidbuf_w_fifo #(
   parameter int WW    = 32,
   parameter int RW    = 128,
   parameter int DEPTH = 2048,
   localparam int WA   = $clog2(DEPTH)
) (
   input  logic          arst_n,
   input  logic          wr_clk,
   input  logic          wr_en,
   input  logic [WW-1:0] wr_dat,
   output logic          full,
   input  logic          rd_clk,
   input  logic          rd_en,
   output logic [RW-1:0] rd_dat,
   output logic [WA:0]   rd_cnt
);
   localparam int RATIO = RW / WW;
   localparam int RB    = $clog2(RATIO);
   localparam int RA    = WA - RB;

   logic [WW-1:0] mem [DEPTH];
   logic [WA:0]   wptr, wgray, wgray_r1, wgray_r2;
   logic [RA:0]   rptr, rgray, rgray_w1, rgray_w2;
   logic [WA:0]   rd_words, wr_words;
   logic [WA-1:0] rd_base;

   function automatic logic [WA:0] g2b_w(input logic [WA:0] g);
      logic [WA:0] b;
      b[WA] = g[WA];
      for (int i = WA - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   function automatic logic [RA:0] g2b_r(input logic [RA:0] g);
      logic [RA:0] b;
      b[RA] = g[RA];
      for (int i = RA - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   // Read pointer counts whole read words so its gray code stays single-bit-change.
   assign rd_words = (WA+1)'(g2b_r(rgray_w2)) << RB;
   assign full     = (wptr - rd_words) == (WA+1)'(DEPTH);
   assign wr_words = g2b_w(wgray_r2);
   assign rd_cnt   = (wr_words - ((WA+1)'(rptr) << RB)) >> RB;
   assign rd_base  = WA'(rptr[RA-1:0]) << RB;

   always_ff @(posedge wr_clk or negedge arst_n) begin
      if (!arst_n) begin
         wptr     <= '0;
         wgray    <= '0;
         rgray_w1 <= '0;
         rgray_w2 <= '0;
      end else begin
         rgray_w1 <= rgray;
         rgray_w2 <= rgray_w1;
         if (wr_en && !full) begin
            wptr  <= wptr + 1'b1;
            wgray <= (wptr + 1'b1) ^ ((wptr + 1'b1) >> 1);
         end
      end
   end

   always_ff @(posedge wr_clk) begin
      if (wr_en && !full) mem[wptr[WA-1:0]] <= wr_dat;
   end

   always_ff @(posedge rd_clk or negedge arst_n) begin
      if (!arst_n) begin
         rptr     <= '0;
         rgray    <= '0;
         wgray_r1 <= '0;
         wgray_r2 <= '0;
      end else begin
         wgray_r1 <= wgray;
         wgray_r2 <= wgray_r1;
         if (rd_en) begin
            rptr  <= rptr + 1'b1;
            rgray <= (rptr + 1'b1) ^ ((rptr + 1'b1) >> 1);
         end
      end
   end

   for (genvar k = 0; k < RATIO; k++) begin : g_rd
      assign rd_dat[k*WW +: WW] = mem[rd_base + WA'(k)];
   end
endmodule

// Frame FSM: one burst request per BURST beats available; FDMA busy is the only backpressure.
module uidbuf_w_quad_baseaddr #(
   parameter int VIDEO_ENABLE   = 1,
   parameter int AXI_DATA_WIDTH = 128,
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int W_BUFDEPTH     = 2048,
   parameter int W_DATAWIDTH    = 32,
   parameter int W_DSIZEBITS    = 24,
   parameter int W_XSIZE        = 1920,
   parameter int W_XSTRIDE      = 1920,
   parameter int W_YSIZE        = 1080,
   parameter int W_XDIV         = 2,
   parameter int W_BUFSIZE      = 3,
   parameter int BASEADDR_0     = 1843200,
   parameter int BASEADDR_1     = 3686400,
   parameter int BASEADDR_2     = 5529600,
   parameter int BASEADDR_3     = 7372800
) (
   input  logic                      I_ui_clk,
   input  logic                      I_ui_rstn,
   input  logic [1:0]                I_quad_sel,
   input  logic                      I_W_clk,
   input  logic                      I_W_FS,
   input  logic                      I_W_wren,
   input  logic [W_DATAWIDTH-1:0]    I_W_data,
   output logic [7:0]                O_W_sync_cnt,
   output logic                      O_W_full,
   output logic [AXI_ADDR_WIDTH-1:0] O_fdma_waddr,
   output logic                      O_fdma_wareq,
   output logic [15:0]               O_fdma_wsize,
   input  logic                      I_fdma_wbusy,
   output logic [AXI_DATA_WIDTH-1:0] O_fdma_wdata,
   input  logic                      I_fdma_wvalid,
   output logic                      O_fdma_wready,
   output logic [7:0]                O_fdma_wbuf,
   output logic                      O_fdma_wirq
`ifdef UIDBUF_W_OVF_FLAG_EN
   ,
   output logic                      O_W_ovf
`endif
);
   localparam int BURST    = W_XSIZE * W_DATAWIDTH / AXI_DATA_WIDTH / W_XDIV;
   localparam int INC      = W_XSIZE * (W_DATAWIDTH / 8) / W_XDIV;
   localparam int LAST_INC = (W_XSTRIDE - W_XSIZE) * (W_DATAWIDTH / 8) + INC;
   localparam int TIMES    = W_YSIZE * W_XDIV;
   localparam int CW       = $clog2(W_BUFDEPTH) + 1;

   typedef enum logic [1:0] {IDLE, RST, DATA1, DATA2} state_t;

   state_t                   state;
   logic [2:0]               fs_sync;
   logic                     fs;
   logic [AXI_ADDR_WIDTH-1:0] base;
   logic [W_DSIZEBITS-1:0]   w_addr;
   logic [15:0]              bcnt;
   logic [7:0]               divcnt;
   logic [6:0]               rstcnt;
   logic [5:0]               irq_cnt;
   logic                     fifo_rst;
   logic [CW-1:0]            rd_cnt;

   assign fs            = (VIDEO_ENABLE != 0) ? (fs_sync[1] & ~fs_sync[2]) : 1'b1;
   assign O_fdma_waddr  = base + AXI_ADDR_WIDTH'({O_W_sync_cnt, w_addr});
   assign O_fdma_wsize  = 16'(BURST);
   assign O_fdma_wready = 1'b1;

   always_ff @(posedge I_ui_clk or negedge I_ui_rstn) begin
      if (!I_ui_rstn) begin
         state        <= IDLE;
         fs_sync      <= '0;
         base         <= AXI_ADDR_WIDTH'(BASEADDR_0);
         w_addr       <= '0;
         bcnt         <= '0;
         divcnt       <= '0;
         rstcnt       <= '0;
         irq_cnt      <= '0;
         fifo_rst     <= 1'b0;
         O_fdma_wareq <= 1'b0;
         O_W_sync_cnt <= '0;
         O_fdma_wbuf  <= '0;
         O_fdma_wirq  <= 1'b0;
      end else begin
         fs_sync <= {fs_sync[1:0], I_W_FS};
         if (O_fdma_wirq) begin
            irq_cnt <= irq_cnt + 6'd1;
            if (irq_cnt == 6'd59) O_fdma_wirq <= 1'b0;
         end
         case (state)
            IDLE: begin
               w_addr <= '0;
               bcnt   <= '0;
               divcnt <= '0;
               rstcnt <= '0;
               // Quadrant is sampled only at frame start so mid-frame changes wait a frame.
               if (fs) begin
                  O_W_sync_cnt <= (O_W_sync_cnt == 8'(W_BUFSIZE - 1)) ? 8'd0 : O_W_sync_cnt + 8'd1;
                  case (I_quad_sel)
                     2'd0: base <= AXI_ADDR_WIDTH'(BASEADDR_0);
                     2'd1: base <= AXI_ADDR_WIDTH'(BASEADDR_1);
                     2'd2: base <= AXI_ADDR_WIDTH'(BASEADDR_2);
                     default: base <= AXI_ADDR_WIDTH'(BASEADDR_3);
                  endcase
                  fifo_rst <= (VIDEO_ENABLE != 0);
                  state    <= RST;
               end
            end
            RST: begin
               if (VIDEO_ENABLE == 0) begin
                  if (!O_fdma_wirq) state <= DATA1;
               end else begin
                  if (rstcnt == 7'd39) fifo_rst <= 1'b0;
                  if (rstcnt == 7'd100) begin
                     if (!O_fdma_wirq) state <= DATA1;
                  end else begin
                     rstcnt <= rstcnt + 7'd1;
                  end
               end
            end
            DATA1: begin
               if (!O_fdma_wareq) begin
                  if (rd_cnt >= CW'(BURST) && !I_fdma_wbusy) O_fdma_wareq <= 1'b1;
               end else if (I_fdma_wbusy) begin
                  O_fdma_wareq <= 1'b0;
                  state        <= DATA2;
               end
            end
            DATA2: begin
               if (!I_fdma_wbusy) begin
                  if (bcnt == 16'(TIMES - 1)) begin
                     O_fdma_wbuf <= O_W_sync_cnt;
                     O_fdma_wirq <= 1'b1;
                     irq_cnt     <= '0;
                     state       <= IDLE;
                  end else begin
                     if (divcnt < 8'(W_XDIV - 1)) begin
                        w_addr <= w_addr + W_DSIZEBITS'(INC);
                        divcnt <= divcnt + 8'd1;
                     end else begin
                        w_addr <= w_addr + W_DSIZEBITS'(LAST_INC);
                        divcnt <= '0;
                     end
                     bcnt  <= bcnt + 16'd1;
                     state <= DATA1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   uidbuf_w_fifo #(
      .WW    (W_DATAWIDTH),
      .RW    (AXI_DATA_WIDTH),
      .DEPTH (W_BUFDEPTH)
   ) u_fifo (
      .arst_n (I_ui_rstn & ~fifo_rst),
      .wr_clk (I_W_clk),
      .wr_en  (I_W_wren),
      .wr_dat (I_W_data),
      .full   (O_W_full),
      .rd_clk (I_ui_clk),
      .rd_en  (I_fdma_wvalid),
      .rd_dat (O_fdma_wdata),
      .rd_cnt (rd_cnt)
   );

`ifdef UIDBUF_W_OVF_FLAG_EN
   logic w_fs_d;
   logic ovf;

   always_ff @(posedge I_W_clk or negedge I_ui_rstn) begin
      if (!I_ui_rstn) begin
         w_fs_d <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         w_fs_d <= I_W_FS;
         if (I_W_FS && !w_fs_d) ovf <= 1'b0;
         else if (I_W_wren && O_W_full) ovf <= 1'b1;
      end
   end

   assign O_W_ovf = ovf;
`endif
endmodule

// File: doc/uidbuf_w_quad_baseaddr.md
Name: uidbuf_w_quad_baseaddr

Overview:
Write-channel frame buffer for the quad-split video path. It takes one camera's pixel stream in the user clock domain and packs it through an async FIFO. It issues FDMA write bursts into DDR at a quadrant base address selected per frame, and rotates through frame buffers. Its O_W_sync_cnt output drives the read-side DBUF buffer-index input (I_R_buf), so display reads a buffer that is not currently being written.

Parameters:
VIDEO_ENABLE, 1, 1 = frame-sync gated FIFO reset per frame; 0 = free-running stream
AXI_DATA_WIDTH, 128, FDMA data width
AXI_ADDR_WIDTH, 32, FDMA address width
W_BUFDEPTH, 2048, FIFO depth in W_DATAWIDTH words
W_DATAWIDTH, 32, user pixel width
W_DSIZEBITS, 24, in-buffer address bits; buffer index sits above them
W_XSIZE, 1920, pixels per line
W_XSTRIDE, 1920, line stride in pixels
W_YSIZE, 1080, lines per frame
W_XDIV, 2, FDMA bursts per line
W_BUFSIZE, 3, frame buffers in rotation (max 128)
BASEADDR_0..BASEADDR_3, 1843200/3686400/5529600/7372800, quadrant base addresses

Ports:
I_ui_clk  in  1  FDMA/AXI clock
I_ui_rstn  in  1  reset
I_quad_sel  in  2  quadrant select, I_ui_clk domain
I_W_clk  in  1  user write clock
I_W_FS  in  1  user frame sync (vsync)
I_W_wren  in  1  pixel write enable
I_W_data  in  W_DATAWIDTH  pixel
O_W_sync_cnt  out  8  buffer index currently being written
O_W_full  out  1  FIFO full, I_W_clk domain
O_fdma_waddr  out  AXI_ADDR_WIDTH  burst address
O_fdma_wareq  out  1  burst request
O_fdma_wsize  out  16  burst length in beats, constant
I_fdma_wbusy  in  1  FDMA busy
O_fdma_wdata  out  AXI_DATA_WIDTH  write data, FIFO show-ahead output
I_fdma_wvalid  in  1  FDMA pops one beat
O_fdma_wready  out  1  tied 1
O_fdma_wbuf  out  8  index of last completed buffer
O_fdma_wirq  out  1  frame-done pulse, 60 cycles

Behaviour:
- Reset: I_ui_rstn is asynchronous, active-low; clock is I_ui_clk. All I_ui_clk-domain registers are set asynchronously at reset.
  - Outputs reset to 0: O_fdma_wareq, O_W_sync_cnt, O_fdma_wbuf, O_fdma_wirq.
  - Base register resets to BASEADDR_0.
  - FIFO is held in reset.
- Derived constants:
  - BURST = W_XSIZE*W_DATAWIDTH/AXI_DATA_WIDTH/W_XDIV
  - INC = W_XSIZE*(W_DATAWIDTH/8)/W_XDIV
  - LAST_INC = (W_XSTRIDE-W_XSIZE)*(W_DATAWIDTH/8)+INC
  - TIMES = W_YSIZE*W_XDIV
- Frame sync: I_W_FS is synchronised into I_ui_clk with a 3-flop chain. Rising edge produces the 1-cycle FS pulse (VIDEO_ENABLE=1). With VIDEO_ENABLE=0, FS is constantly 1.
- Base register: loaded on each FS pulse from I_quad_sel, 0..3 → BASEADDR_0..3. I_quad_sel changes mid-frame take effect at the next frame.
- Address: O_fdma_waddr = base + {O_W_sync_cnt, W_addr[W_DSIZEBITS-1:0]}, zero-extended/truncated to AXI_ADDR_WIDTH.
- FSM states: IDLE, RST, DATA1, DATA2.
  - IDLE: W_addr, bcnt, divcnt, rstcnt cleared. On FS, O_W_sync_cnt increments, wrapping W_BUFSIZE-1 → 0, then go to RST.
  - RST (VIDEO_ENABLE=1): FIFO reset asserted for rstcnt 0..39, released for 40..99. At 100, go to DATA1 once O_fdma_wirq=0. With VIDEO_ENABLE=0, go to DATA1 immediately if irq=0.
  - DATA1: when FIFO read-side count >= BURST and I_fdma_wbusy=0, assert O_fdma_wareq. Drop it on the first cycle busy=1, then go to DATA2.
  - DATA2: on busy=0, if bcnt==TIMES-1 go to IDLE. Otherwise:
    - divcnt<W_XDIV-1: W_addr += INC, divcnt++
    - else: W_addr += LAST_INC, divcnt=0
    - bcnt++, go to DATA1
- FS arriving outside IDLE is ignored; the frame is completed first.
- On the DATA2→IDLE transition: O_fdma_wbuf <= O_W_sync_cnt and O_fdma_wirq held 1 for 60 cycles.
- FIFO: async, write W_DATAWIDTH / read AXI_DATA_WIDTH, show-ahead, read enable = I_fdma_wvalid. Reset = !I_ui_rstn | fifo_rst.
  - FIFO full: user writes are dropped.
  - I_fdma_wvalid on an empty FIFO has undefined data; unreachable by the request rule.
- O_W_full is the FIFO full flag.

Optional Feature:
UIDBUF_W_OVF_FLAG_EN:
- Defined: adds output O_W_ovf (1 bit, I_W_clk domain), sticky-set when I_W_wren=1 while full. It is cleared by the FS edge in the I_W_clk domain and by reset.
- Undefined: port absent, no logic.

Test Plan:
1. Parameters W_XSIZE=16, W_XSTRIDE=32, W_YSIZE=4, W_XDIV=2, W_BUFSIZE=3 (BURST=2, INC=32, LAST_INC=96, TIMES=8). Stimulus: I_quad_sel=0, FS, 64 pixels. Response: 8 requests, wsize=2. Addresses:
   - 1843200 + (1<<24) + {0, 32, 128, 160, 256, 288, 384, 416}
   - O_fdma_wbuf=1, irq high exactly 60 cycles
2. Four frames → O_W_sync_cnt sequence 1, 2, 0, 1; address upper bits follow.
3. I_quad_sel=2 set mid-frame → current frame keeps the old base; next frame's first address = 5529600 + (sync_cnt<<24).
4. FS pulse during DATA2 → ignored, frame finishes 8 bursts, no counter skip.
5. I_ui_rstn low during DATA2 → wareq, sync_cnt, wbuf, irq immediately 0; after release, the first FS restarts at W_addr=0.
6. With UIDBUF_W_OVF_FLAG_EN: hold busy=1, write 2049 words → O_W_full=1, O_W_ovf=1 until the next FS.
